// File: rtl/flag_unit.sv
// 8085 PSW flag register: per-class S/Z/AC/P/CY updates, PUSH/POP PSW bus
// exchange, and registered branch-condition evaluation.
module flag_unit #(
  parameter logic [7:0] PSW_RESET = 8'h02
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       alu_sign,
  input  logic       alu_zero,
  input  logic       alu_parity,
  input  logic       alu_carry,
  input  logic       alu_aux,
  input  logic       rot_carry,
  input  logic       cy_set,
  input  logic [2:0] flag_mode,
  input  logic       flag_load,
  input  logic       flag_to_dbus,
  inout  wire  [7:0] flagdbus,
  input  logic [2:0] cond,
  input  logic       cond_eval,
  output logic       cond_true,
  output logic [7:0] flags
);

  localparam int BIT_S  = 7;
  localparam int BIT_Z  = 6;
  localparam int BIT_AC = 4;
  localparam int BIT_P  = 2;
  localparam int BIT_CY = 0;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_ADD  = 3'b001;
  localparam logic [2:0] MODE_SUB  = 3'b010;
  localparam logic [2:0] MODE_AND  = 3'b011;
  localparam logic [2:0] MODE_OR   = 3'b100;
  localparam logic [2:0] MODE_INR  = 3'b101;
  localparam logic [2:0] MODE_ROT  = 3'b110;
  localparam logic [2:0] MODE_CYOP = 3'b111;

  logic [7:0] flags_q, flags_d;
  logic       cond_q, cond_d;

  // Bits 5 and 3 always read 0, bit 1 always reads 1.
  function automatic logic [7:0] force_fixed(input logic [7:0] v);
    force_fixed = {v[7:6], 1'b0, v[4], 1'b0, v[2], 1'b1, v[0]};
  endfunction

  function automatic logic eval_cond(input logic [2:0] ccc, input logic [7:0] psw);
    case (ccc)
      3'b000:  eval_cond = ~psw[BIT_Z];
      3'b001:  eval_cond =  psw[BIT_Z];
      3'b010:  eval_cond = ~psw[BIT_CY];
      3'b011:  eval_cond =  psw[BIT_CY];
      3'b100:  eval_cond = ~psw[BIT_P];
      3'b101:  eval_cond =  psw[BIT_P];
      3'b110:  eval_cond = ~psw[BIT_S];
      default: eval_cond =  psw[BIT_S];
    endcase
  endfunction

  assign flagdbus = (rst && flag_to_dbus) ? flags_q : 8'bzzzz_zzzz;

  always_comb begin
    flags_d = flags_q;
    // P is even parity, so the ALU's odd-parity indication is inverted.
    case (flag_mode)
      MODE_HOLD: ;
      MODE_ADD, MODE_SUB, MODE_AND, MODE_OR, MODE_INR: begin
        flags_d[BIT_S] = alu_sign;
        flags_d[BIT_Z] = alu_zero;
        flags_d[BIT_P] = ~alu_parity;
        case (flag_mode)
          MODE_ADD: begin
            flags_d[BIT_AC] = alu_aux;
            flags_d[BIT_CY] = alu_carry;
          end
          MODE_SUB: begin
            flags_d[BIT_AC] = ~alu_aux;
            flags_d[BIT_CY] = ~alu_carry;
          end
          MODE_AND: begin
            flags_d[BIT_AC] = 1'b1;
            flags_d[BIT_CY] = 1'b0;
          end
          MODE_OR: begin
            flags_d[BIT_AC] = 1'b0;
            flags_d[BIT_CY] = 1'b0;
          end
          default: flags_d[BIT_AC] = alu_aux;
        endcase
      end
      MODE_ROT:  flags_d[BIT_CY] = rot_carry;
      MODE_CYOP: flags_d[BIT_CY] = cy_set ? 1'b1 : ~flags_q[BIT_CY];
      default: ;
    endcase
    if (flag_load) begin
      flags_d = flagdbus;
    end
    flags_d = force_fixed(flags_d);
  end

  always_comb begin
    cond_d = cond_q;
    if (cond_eval) begin
      cond_d = eval_cond(cond, flags_q);
    end
  end

  always_ff @(posedge phi2) begin
    if (!rst) begin
      flags_q <= PSW_RESET;
      cond_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  assign flags     = flags_q;
  assign cond_true = cond_q;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed walk through the PSW behaviour, then random
// cycles checked against a flag-by-flag behavioural model.
module tb_flag_unit;

  logic       phi2 = 1'b0;
  logic       rst;
  logic       alu_sign, alu_zero, alu_parity, alu_carry, alu_aux;
  logic       rot_carry, cy_set;
  logic [2:0] flag_mode;
  logic       flag_load, flag_to_dbus;
  logic [2:0] cond;
  logic       cond_eval;
  logic       cond_true;
  logic [7:0] flags;

  logic       tb_en;
  logic [7:0] tb_val;
  wire  [7:0] flagdbus;
  assign flagdbus = tb_en ? tb_val : 8'bzzzz_zzzz;

  int checks = 0;
  int failures = 0;

  // Reference state, one variable per architectural flag.
  bit m_s, m_z, m_ac, m_p, m_cy;
  bit m_cond;

  flag_unit #(.PSW_RESET(8'h02)) dut (
    .phi2(phi2), .rst(rst),
    .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_parity(alu_parity),
    .alu_carry(alu_carry), .alu_aux(alu_aux), .rot_carry(rot_carry),
    .cy_set(cy_set), .flag_mode(flag_mode), .flag_load(flag_load),
    .flag_to_dbus(flag_to_dbus), .flagdbus(flagdbus), .cond(cond),
    .cond_eval(cond_eval), .cond_true(cond_true), .flags(flags)
  );

  always #5 phi2 = ~phi2;

  function automatic logic [7:0] model_psw();
    logic [7:0] p;
    p = 8'h02;
    if (m_s)  p = p + 8'h80;
    if (m_z)  p = p + 8'h40;
    if (m_ac) p = p + 8'h10;
    if (m_p)  p = p + 8'h04;
    if (m_cy) p = p + 8'h01;
    return p;
  endfunction

  function automatic bit model_cond(input logic [2:0] c);
    case (c)
      3'd0: return !m_z;
      3'd1: return m_z;
      3'd2: return !m_cy;
      3'd3: return m_cy;
      3'd4: return !m_p;
      3'd5: return m_p;
      3'd6: return !m_s;
      default: return m_s;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the current inputs across one rising edge, advancing the model.
  task automatic tick(input string tag);
    logic [7:0] bus_exp;
    bit         nc;
    tb_en = !(rst && flag_to_dbus);
    #1;
    bus_exp = tb_en ? tb_val : model_psw();
    chk({tag, "_bus"}, flagdbus, bus_exp);
    nc = cond_eval ? model_cond(cond) : m_cond;
    if (!rst) begin
      {m_s, m_z, m_ac, m_p, m_cy} = 5'b00000;
      nc = 1'b0;
    end else if (flag_load) begin
      {m_s, m_z, m_ac, m_p, m_cy} = {bus_exp[7], bus_exp[6], bus_exp[4], bus_exp[2], bus_exp[0]};
    end else begin
      if (flag_mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) begin
        m_s = alu_sign;
        m_z = alu_zero;
        m_p = !alu_parity;
      end
      case (flag_mode)
        3'd1: begin m_ac = alu_aux;  m_cy = alu_carry;  end
        3'd2: begin m_ac = !alu_aux; m_cy = !alu_carry; end
        3'd3: begin m_ac = 1'b1;     m_cy = 1'b0;       end
        3'd4: begin m_ac = 1'b0;     m_cy = 1'b0;       end
        3'd5: m_ac = alu_aux;
        3'd6: m_cy = rot_carry;
        3'd7: m_cy = cy_set ? 1'b1 : !m_cy;
        default: ;
      endcase
    end
    m_cond = nc;
    @(posedge phi2);
    #1;
    chk({tag, "_flags"}, flags, model_psw());
    chk({tag, "_cond"}, {7'd0, cond_true}, {7'd0, m_cond});
  endtask

  task automatic idle();
    rst = 1'b1; flag_mode = 3'd0; flag_load = 1'b0; flag_to_dbus = 1'b0;
    cond_eval = 1'b0; cond = 3'd0; tb_val = 8'h00; cy_set = 1'b0; rot_carry = 1'b0;
    {alu_sign, alu_zero, alu_parity, alu_carry, alu_aux} = 5'b00000;
  endtask

  task automatic alu(input logic s, z, p, c, a);
    {alu_sign, alu_zero, alu_parity, alu_carry, alu_aux} = {s, z, p, c, a};
  endtask

  initial begin
    idle();
    tb_en = 1'b1;
    @(posedge phi2); #1;

    // Reset with load and bus request active; bus must stay released.
    rst = 1'b0; flag_load = 1'b1; flag_to_dbus = 1'b1; tb_val = 8'h00;
    tick("reset");
    chk("reset_psw", flags, 8'h02);
    chk("reset_cond", {7'd0, cond_true}, 8'h00);

    idle(); flag_mode = 3'd1; alu(1, 0, 1, 1, 1);
    tick("add");
    chk("add_psw", flags, 8'h93);
    idle(); flag_mode = 3'd5; alu(0, 1, 0, 0, 0);
    tick("inr");
    chk("inr_psw", flags, 8'h47);

    idle(); flag_mode = 3'd2; alu(0, 1, 0, 1, 1);
    tick("sub");
    chk("sub_psw", flags, 8'h46);

    // Conditions against 8'h46.
    idle(); cond_eval = 1'b1; cond = 3'd1; tick("c_z");  chk("cond_z",  {7'd0, cond_true}, 8'h01);
    idle(); cond_eval = 1'b1; cond = 3'd2; tick("c_nc"); chk("cond_nc", {7'd0, cond_true}, 8'h01);
    idle(); cond_eval = 1'b1; cond = 3'd3; tick("c_c");  chk("cond_c",  {7'd0, cond_true}, 8'h00);
    idle(); tick("c_hold"); chk("cond_hold", {7'd0, cond_true}, 8'h00);
    idle(); cond_eval = 1'b1; cond = 3'd5; tick("c_pe"); chk("cond_pe", {7'd0, cond_true}, 8'h01);
    idle(); cond_eval = 1'b1; cond = 3'd6; tick("c_p");  chk("cond_p",  {7'd0, cond_true}, 8'h01);

    // Condition sees pre-update Z while the same edge clears Z.
    idle(); cond_eval = 1'b1; cond = 3'd1; flag_mode = 3'd1; alu(0, 0, 0, 0, 0);
    tick("hazard");
    chk("hazard_cond", {7'd0, cond_true}, 8'h01);
    chk("hazard_psw", flags, 8'h06);

    idle(); flag_mode = 3'd2; alu(0, 1, 0, 1, 1); tick("sub2");
    idle(); flag_mode = 3'd3; alu(0, 1, 0, 1, 1); tick("and");
    chk("and_psw", flags, 8'h56);
    idle(); flag_mode = 3'd7; cy_set = 1'b0; tick("cmc1"); chk("cmc1_cy", {7'd0, flags[0]}, 8'h01);
    idle(); flag_mode = 3'd7; cy_set = 1'b0; tick("cmc2"); chk("cmc2_cy", {7'd0, flags[0]}, 8'h00);
    idle(); flag_mode = 3'd7; cy_set = 1'b1; tick("stc");  chk("stc_cy",  {7'd0, flags[0]}, 8'h01);
    idle(); flag_mode = 3'd6; rot_carry = 1'b0; tick("rot"); chk("rot_psw", flags, 8'h56);

    // POP PSW wins over a simultaneous add; then PUSH PSW and self-reload.
    idle(); flag_load = 1'b1; flag_mode = 3'd1; tb_val = 8'hFF; alu(0, 0, 0, 0, 0);
    tick("pop");
    chk("pop_psw", flags, 8'hD7);
    idle(); flag_to_dbus = 1'b1;
    tick("push");
    idle(); flag_to_dbus = 1'b1; flag_load = 1'b1;
    tick("pushpop");
    chk("pushpop_psw", flags, 8'hD7);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 39) != 0);
      flag_mode    = 3'($urandom_range(0, 7));
      flag_load    = ($urandom_range(0, 6) == 0);
      flag_to_dbus = ($urandom_range(0, 5) == 0);
      tb_val       = 8'($urandom);
      cond         = 3'($urandom_range(0, 7));
      cond_eval    = ($urandom_range(0, 2) == 0);
      cy_set       = 1'($urandom);
      rot_carry    = 1'($urandom);
      {alu_sign, alu_zero, alu_parity, alu_carry, alu_aux} = 5'($urandom);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
